// File: rtl/fp32_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp32_mul_arbiter
// Brief    : Shares one fixed-latency pipelined FP32 multiplier among N_REQ
//            valid/ready requesters and tags each result with its issuer id.
// Revision : 1.0
// ============================================================================
module fp32_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  prio_mode,
  input  logic                  stall,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_f,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_f,
  output logic [2:0]            inflight,
  output logic                  busy
);

  localparam logic [ID_W-1:0] c_last_id = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]  r_rr_ptr;
  logic [MUL_LAT-1:0] r_tag_v;
  logic [ID_W-1:0]  r_tag_id [MUL_LAT];
  logic [2:0]       r_inflight;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_gid;
  logic             w_found;
  logic             w_issue;
  logic [31:0]      w_mul_a;
  logic [31:0]      w_mul_b;

  // Grant search: fixed priority scans from 0, round-robin scans from r_rr_ptr.
  always_comb begin
    w_grant = '0;
    w_gid   = '0;
    w_found = 1'b0;
    if (!stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (prio_mode) begin
          if (req_valid[k] && !w_found) begin
            w_found = 1'b1;
            w_gid   = ID_W'(k);
          end
        end else begin
          if (req_valid[(int'(r_rr_ptr) + k) % N_REQ] && !w_found) begin
            w_found = 1'b1;
            w_gid   = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
          end
        end
      end
      if (w_found) w_grant[w_gid] = 1'b1;
    end
  end

  assign w_issue = |(req_valid & w_grant);

  always_comb begin
    w_mul_a = 32'h0;
    w_mul_b = 32'h0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i] && req_valid[i]) begin
        w_mul_a = req_a[32*i +: 32];
        w_mul_b = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= (w_gid == c_last_id) ? '0 : w_gid + 1'b1;
    end
  end

  // Tag shift register mirrors the multiplier pipeline one-for-one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_v <= '0;
      for (int s = 0; s < MUL_LAT; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_v     <= {r_tag_v[MUL_LAT-2:0], w_issue};
      r_tag_id[0] <= w_gid;
      for (int s = 1; s < MUL_LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 3'd0;
    end else begin
      case ({w_issue, r_tag_v[MUL_LAT-1]})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign mul_a      = w_mul_a;
  assign mul_b      = w_mul_b;
  assign resp_valid = r_tag_v[MUL_LAT-1];
  assign resp_id    = r_tag_id[MUL_LAT-1];
  assign resp_f     = mul_f;
  assign inflight   = r_inflight;
  assign busy       = (r_inflight != 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_fp32_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_mul_arbiter
// Brief    : Self-checking bench for fp32_mul_arbiter with a queue-based model
//            of issued ops and a behavioural pipelined multiplier.
// Revision : 1.0
// ============================================================================
module tb_fp32_mul_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic              prio_mode;
  logic              stall;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic [31:0]       mul_f;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       resp_f;
  logic [2:0]        inflight;
  logic              busy;

  int total = 0;
  int bad   = 0;

  fp32_mul_arbiter #(.N_REQ(N), .ID_W(IDW), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .prio_mode(prio_mode), .stall(stall),
    .mul_a(mul_a), .mul_b(mul_b), .mul_f(mul_f),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_f(resp_f),
    .inflight(inflight), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simplified FP32 multiply for normal operands (truncating); stands in for the real unit.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] ma, mb, p;
    logic [22:0] m;
    int e;
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else       m = p[45:23];
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  logic [31:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= fmul(mul_a, mul_b);
    for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
  end
  assign mul_f = mp[LAT-1];

  // Reference model: list of outstanding ops keyed by the cycle their result is due.
  typedef struct { int due; int id; logic [31:0] f; } ent_t;
  ent_t pend[$];
  int   ptr = 0;
  int   cyc = 0;

  function automatic int model_gid();
    if (stall) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = prio_mode ? k : (ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
      ptr = 0;
    end else begin
      int g;
      g = model_gid();
      if (g >= 0) begin
        pend.push_back('{cyc + LAT, g, fmul(req_a[32*g +: 32], req_b[32*g +: 32])});
        ptr = (g + 1) % N;
      end
      cyc++;
      while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    end
  end

  logic [N-1:0]   exp_gnt;
  logic [31:0]    exp_a, exp_b, exp_rf;
  logic           exp_rv;
  logic [IDW-1:0] exp_rid;
  logic [2:0]     exp_infl;

  task automatic model_eval();
    int g;
    g = model_gid();
    exp_gnt  = (g >= 0) ? N'(1 << g) : '0;
    exp_a    = (g >= 0) ? req_a[32*g +: 32] : 32'h0;
    exp_b    = (g >= 0) ? req_b[32*g +: 32] : 32'h0;
    exp_rv   = (pend.size() > 0) && (pend[0].due == cyc);
    exp_rid  = exp_rv ? IDW'(pend[0].id) : '0;
    exp_rf   = exp_rv ? pend[0].f : 32'h0;
    exp_infl = 3'(pend.size());
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
      req_b[32*i +: 32] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; prio_mode = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL reset_resp_id: got %0d want 0", resp_id); end
    total++; if (busy !== 1'b0 || inflight !== 3'd0) begin bad++; $display("FAIL reset_busy: got busy=%b inflight=%0d want 0/0", busy, inflight); end
    next_cycle();
    rst = 1'b1;
    repeat (2) next_cycle();
  endtask

  task automatic test_single();
    req_a[64 +: 32] = 32'h40000000;
    req_b[64 +: 32] = 32'h40400000;
    req_valid = 4'b0100;
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    total++; if (mul_a !== 32'h40000000 || mul_b !== 32'h40400000) begin bad++; $display("FAIL single_ops: got %h %h want 40000000 40400000", mul_a, mul_b); end
    next_cycle();
    req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++; if (resp_valid !== (k == 4)) begin bad++; $display("FAIL single_resp_valid k=%0d: got %b want %b", k, resp_valid, (k == 4)); end
      if (k == 4) begin
        total++; if (resp_id !== 2'd2 || resp_f !== 32'h40C00000) begin bad++; $display("FAIL single_resp: got id=%0d f=%h want 2 40c00000", resp_id, resp_f); end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      model_eval();
      if (k < 8) begin
        total++; if (req_ready !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_grant k=%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4))); end
        total++; if (mul_a !== exp_a || mul_b !== exp_b) begin bad++; $display("FAIL rr_ops k=%0d: got %h %h want %h %h", k, mul_a, mul_b, exp_a, exp_b); end
      end
      if (k >= 4) begin
        total++; if (resp_valid !== 1'b1 || resp_id !== 2'((k - 4) % 4) || resp_f !== exp_rf) begin
          bad++; $display("FAIL rr_resp k=%0d: got v=%b id=%0d f=%h want 1 %0d %h", k, resp_valid, resp_id, resp_f, (k - 4) % 4, exp_rf); end
      end
      total++; if (inflight !== exp_infl) begin bad++; $display("FAIL rr_inflight k=%0d: got %0d want %0d", k, inflight, exp_infl); end
      if (k >= 4 && k <= 8) begin
        total++; if (inflight !== 3'd4) begin bad++; $display("FAIL rr_saturate k=%0d: got %0d want 4", k, inflight); end
      end
      next_cycle();
    end
  endtask

  task automatic test_priority();
    logic [3:0] want [7];
    want = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      prio_mode = (k < 3);
      req_valid = (k < 7) ? 4'b1010 : 4'b0000;
      @(negedge clk);
      model_eval();
      if (k < 7) begin
        total++; if (req_ready !== want[k]) begin bad++; $display("FAIL prio_grant k=%0d: got %b want %b", k, req_ready, want[k]); end
      end
      total++; if (resp_valid !== exp_rv || (exp_rv && (resp_id !== exp_rid || resp_f !== exp_rf))) begin
        bad++; $display("FAIL prio_resp k=%0d: got v=%b id=%0d f=%h want %b %0d %h", k, resp_valid, resp_id, resp_f, exp_rv, exp_rid, exp_rf); end
      next_cycle();
    end
    prio_mode = 1'b0;
  endtask

  task automatic test_stall();
    for (int k = 0; k < 7; k++) begin
      rand_ops();
      stall     = (k == 1 || k == 2);
      req_valid = (k < 3) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      model_eval();
      if (k == 1 || k == 2) begin
        total++; if (req_ready !== 4'b0000 || mul_a !== 32'h0 || mul_b !== 32'h0) begin
          bad++; $display("FAIL stall_idle k=%0d: got ready=%b a=%h b=%h want 0 0 0", k, req_ready, mul_a, mul_b); end
      end
      total++; if (resp_valid !== (k == 4) || resp_valid !== exp_rv) begin bad++; $display("FAIL stall_resp k=%0d: got %b want %b", k, resp_valid, (k == 4)); end
      if (k == 4) begin
        total++; if (resp_id !== 2'd0 || resp_f !== exp_rf) begin bad++; $display("FAIL stall_resp_data: got id=%0d f=%h want 0 %h", resp_id, resp_f, exp_rf); end
      end
      next_cycle();
    end
    stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1111;
    repeat (3) begin rand_ops(); next_cycle(); end
    req_valid = '0;
    rst = 1'b0;
    #1;
    total++; if (inflight !== 3'd0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_clear: got infl=%0d busy=%b rv=%b want 0 0 0", inflight, busy, resp_valid); end
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k == 3) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      model_eval();
      total++; if (resp_valid !== (k == 7)) begin bad++; $display("FAIL midreset_resp k=%0d: got %b want %b", k, resp_valid, (k == 7)); end
      if (k == 7) begin
        total++; if (resp_id !== 2'd0 || resp_f !== exp_rf) begin bad++; $display("FAIL midreset_data: got id=%0d f=%h want 0 %h", resp_id, resp_f, exp_rf); end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int r, seen;
    r = $urandom_range(0, N - 1);
    seen = 0;
    for (int n = 0; n < 104; n++) begin
      rand_ops();
      prio_mode = 1'($urandom);
      req_valid = (n < 100) ? 4'(1 << r) : 4'b0000;
      @(negedge clk);
      model_eval();
      total++; if (req_ready !== exp_gnt) begin bad++; $display("FAIL b2b_grant n=%0d: got %b want %b", n, req_ready, exp_gnt); end
      total++; if (resp_valid !== exp_rv || (exp_rv && (resp_id !== exp_rid || resp_f !== exp_rf))) begin
        bad++; $display("FAIL b2b_resp n=%0d: got v=%b id=%0d f=%h want %b %0d %h", n, resp_valid, resp_id, resp_f, exp_rv, exp_rid, exp_rf); end
      if (n >= 4 && n < 100) begin
        total++; if (inflight !== 3'd4) begin bad++; $display("FAIL b2b_inflight n=%0d: got %0d want 4", n, inflight); end
      end
      if (resp_valid === 1'b1) seen++;
      next_cycle();
    end
    @(negedge clk);
    total++; if (seen != 100) begin bad++; $display("FAIL b2b_count: got %0d want 100", seen); end
    total++; if (busy !== 1'b0 || inflight !== 3'd0) begin bad++; $display("FAIL b2b_drain: got busy=%b infl=%0d want 0 0", busy, inflight); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
